// File: rtl/ysyx_25060170_pkg.sv
// Shared constants and requester ids for the GPR write-back slice.
// Config: YSYX_25060170_SCOREBOARD_EN enables the busy scoreboard.
package ysyx_25060170_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREG       = 32;

    typedef enum logic {
        REQ_EXU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

endpackage

// File: rtl/ysyx_25060170_rr_arb2.sv
// Two-input round-robin arbiter; the requester granted last loses a tie.
// Config: none (see YSYX_25060170_SCOREBOARD_EN in the top).
module ysyx_25060170_rr_arb2
    import ysyx_25060170_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    req_id_e last_q;
    req_id_e last_d;

    always_comb begin
        gnt    = req;
        last_d = last_q;
        if (req == 2'b11) begin
            gnt = (last_q == REQ_LSU) ? 2'b01 : 2'b10;
        end
        if (accept) begin
            last_d = gnt[1] ? REQ_LSU : REQ_EXU;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= REQ_LSU;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ysyx_25060170_gpr_wb_ctrl.sv
// GPR write-back arbiter, registered write port and RAW/WAW busy scoreboard.
// Config: YSYX_25060170_SCOREBOARD_EN enables busy/hazard_stall tracking.
module ysyx_25060170_gpr_wb_ctrl #(
    parameter int XLEN = ysyx_25060170_pkg::XLEN,
    parameter int NREG = ysyx_25060170_pkg::NREG
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  issue_valid,
    input  logic [ysyx_25060170_pkg::REG_ADDR_W-1:0] issue_rd,
    input  logic [ysyx_25060170_pkg::REG_ADDR_W-1:0] rs1,
    input  logic [ysyx_25060170_pkg::REG_ADDR_W-1:0] rs2,
    output logic                                  hazard_stall,
    input  logic                                  exu_valid,
    output logic                                  exu_ready,
    input  logic [ysyx_25060170_pkg::REG_ADDR_W-1:0] exu_rd,
    input  logic [XLEN-1:0]                       exu_data,
    input  logic                                  lsu_valid,
    output logic                                  lsu_ready,
    input  logic [ysyx_25060170_pkg::REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]                       lsu_data,
    output logic                                  gpr_we,
    output logic [ysyx_25060170_pkg::REG_ADDR_W-1:0] gpr_waddr,
    output logic [XLEN-1:0]                       gpr_wdata,
    output logic [NREG-1:0]                       busy
);

    import ysyx_25060170_pkg::*;

    logic [1:0]            gnt;
    logic                  accept;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;

    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;

    ysyx_25060170_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({lsu_valid, exu_valid}),
        .accept (accept),
        .gnt    (gnt)
    );

    assign exu_ready = gnt[0];
    assign lsu_ready = gnt[1];
    assign accept    = |gnt;

    always_comb begin
        sel_rd   = gnt[1] ? lsu_rd : exu_rd;
        sel_data = gnt[1] ? lsu_data : exu_data;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        if (accept) begin
            we_d    = (sel_rd != '0);
            waddr_d = sel_rd;
            wdata_d = sel_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign gpr_we    = we_q;
    assign gpr_waddr = waddr_q;
    assign gpr_wdata = wdata_q;

`ifdef YSYX_25060170_SCOREBOARD_EN
    logic [NREG-1:0] busy_q, busy_d;
    logic [NREG-1:0] set_v, clr_v;
    logic            set_ok;

    assign hazard_stall = busy_q[rs1] | busy_q[rs2] | busy_q[issue_rd];
    assign set_ok       = issue_valid & ~hazard_stall & (issue_rd != '0);

    // Set is applied after clear so a fresh claim survives a same-edge commit.
    always_comb begin
        set_v = '0;
        clr_v = '0;
        for (int i = 1; i < NREG; i++) begin
            set_v[i] = set_ok && (issue_rd == REG_ADDR_W'(i));
            clr_v[i] = we_q && (waddr_q == REG_ADDR_W'(i));
        end
        busy_d = (busy_q & ~clr_v) | set_v;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
`else
    logic unused_sb;

    assign unused_sb    = ^{issue_valid, issue_rd, rs1, rs2};
    assign hazard_stall = 1'b0;
    assign busy         = '0;
`endif

endmodule

// File: tb/tb_ysyx_25060170_gpr_wb_ctrl.sv
// Self-checking bench: directed literal cases plus randomized traffic vs a model.
// Config: follows YSYX_25060170_SCOREBOARD_EN like the design.
module tb_ysyx_25060170_gpr_wb_ctrl;

`ifdef YSYX_25060170_SCOREBOARD_EN
    localparam bit SB_ON = 1'b1;
`else
    localparam bit SB_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0, rs1 = '0, rs2 = '0;
    logic        hazard_stall;
    logic        exu_valid = 1'b0, lsu_valid = 1'b0;
    logic        exu_ready, lsu_ready;
    logic [4:0]  exu_rd = '0, lsu_rd = '0;
    logic [31:0] exu_data = '0, lsu_data = '0;
    logic        gpr_we;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic [31:0] busy;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_25060170_gpr_wb_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .hazard_stall (hazard_stall),
        .exu_valid    (exu_valid),
        .exu_ready    (exu_ready),
        .exu_rd       (exu_rd),
        .exu_data     (exu_data),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .gpr_we       (gpr_we),
        .gpr_waddr    (gpr_waddr),
        .gpr_wdata    (gpr_wdata),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Reference model: who went last, pending-write set, last write issued.
    bit          m_last_lsu = 1'b1;
    bit          m_busy [32];
    bit          m_we = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;
    bit          acc_e = 1'b0, acc_l = 1'b0;

    function automatic bit exp_exu_ready();
        return exu_valid && (!lsu_valid || m_last_lsu);
    endfunction

    function automatic bit exp_lsu_ready();
        return lsu_valid && !exp_exu_ready();
    endfunction

    function automatic bit exp_stall();
        return m_busy[rs1] || m_busy[rs2] || m_busy[issue_rd];
    endfunction

    function automatic logic [31:0] exp_busy();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit ge, gl, st;
        if (rst) begin
            m_last_lsu = 1'b1;
            m_we       = 1'b0;
            m_waddr    = '0;
            m_wdata    = '0;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            acc_e = 1'b0;
            acc_l = 1'b0;
        end else begin
            ge = exp_exu_ready();
            gl = exp_lsu_ready();
            st = exp_stall();
            if (m_we) m_busy[m_waddr] = 1'b0;
            if (SB_ON && issue_valid && !st && issue_rd != 0)
                m_busy[issue_rd] = 1'b1;
            if (ge) begin
                m_we = (exu_rd != 0); m_waddr = exu_rd; m_wdata = exu_data;
                m_last_lsu = 1'b0;
            end else if (gl) begin
                m_we = (lsu_rd != 0); m_waddr = lsu_rd; m_wdata = lsu_data;
                m_last_lsu = 1'b1;
            end else begin
                m_we = 1'b0;
            end
            acc_e = ge;
            acc_l = gl;
        end
    end

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_exu_ready", 64'(exu_ready), 64'(exp_exu_ready()));
            chk("m_lsu_ready", 64'(lsu_ready), 64'(exp_lsu_ready()));
            chk("m_gpr_we", 64'(gpr_we), 64'(m_we));
            chk("m_gpr_waddr", 64'(gpr_waddr), 64'(m_waddr));
            chk("m_gpr_wdata", 64'(gpr_wdata), 64'(m_wdata));
            chk("m_busy", 64'(busy), 64'(exp_busy()));
            chk("m_stall", 64'(hazard_stall), 64'(exp_stall()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_we", 64'(gpr_we), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);

        // Conflict after reset: EXU first, then LSU.
        exu_valid = 1; exu_rd = 5'd1; exu_data = 32'h11;
        lsu_valid = 1; lsu_rd = 5'd2; lsu_data = 32'h22;
        #1 chk("conf_exu_rdy", 64'({exu_ready, lsu_ready}), 64'b10);
        tick();
        exu_valid = 0;
        chk("conf_w1", 64'({gpr_we, gpr_waddr, gpr_wdata}), {1'b1, 5'd1, 32'h11});
        chk("conf_lsu_rdy", 64'(lsu_ready), 64'h1);
        tick();
        lsu_valid = 0;
        chk("conf_w2", 64'({gpr_we, gpr_waddr, gpr_wdata}), {1'b1, 5'd2, 32'h22});
        tick();
        chk("conf_idle", 64'(gpr_we), 64'h0);

        // Single write.
        exu_valid = 1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF;
        #1 chk("single_rdy", 64'(exu_ready), 64'h1);
        tick();
        exu_valid = 0;
        chk("single_w", 64'({gpr_we, gpr_waddr, gpr_wdata}),
            {1'b1, 5'd5, 32'hDEADBEEF});

        // x0 write is accepted but never commits.
        lsu_valid = 1; lsu_rd = 5'd0; lsu_data = 32'h55;
        #1 chk("x0_rdy", 64'(lsu_ready), 64'h1);
        tick();
        lsu_valid = 0;
        chk("x0_we", 64'({gpr_we, gpr_waddr}), {1'b0, 5'd0});

        // RAW on r7.
        issue_valid = 1; issue_rd = 5'd7;
        tick();
        issue_valid = 0; issue_rd = 5'd0; rs1 = 5'd7;
        #1 chk("raw_stall0", 64'(hazard_stall), 64'(SB_ON));
        exu_valid = 1; exu_rd = 5'd7; exu_data = 32'h77;
        tick();
        exu_valid = 0;
        chk("raw_stall1", 64'(hazard_stall), 64'(SB_ON));
        chk("raw_we", 64'({gpr_we, gpr_waddr}), {1'b1, 5'd7});
        tick();
        chk("raw_stall2", 64'(hazard_stall), 64'h0);
        rs1 = 5'd0;

        // Set/clear collision on r3.
        exu_valid = 1; exu_rd = 5'd3; exu_data = 32'h33;
        tick();
        exu_valid = 0;
        issue_valid = 1; issue_rd = 5'd3;
        tick();
        issue_valid = 0; issue_rd = 5'd0;
        chk("coll_busy3", 64'(busy[3]), 64'(SB_ON));
        tick();
        chk("coll_busy3b", 64'(busy[3]), 64'(SB_ON));
        exu_valid = 1; exu_rd = 5'd3; exu_data = 32'h34;
        tick();
        exu_valid = 0;
        tick();
        chk("coll_clr3", 64'(busy[3]), 64'h0);

        // Asynchronous reset with r8..r11 pending and a write in flight.
        for (int r = 8; r < 12; r++) begin
            issue_valid = 1; issue_rd = 5'(r);
            tick();
        end
        issue_valid = 0; issue_rd = 5'd0;
        exu_valid = 1; exu_rd = 5'd12; exu_data = 32'hC0FFEE;
        tick();
        exu_valid = 0;
        chk("pre_rst_busy", 64'(busy), 64'(SB_ON ? 32'h0F00 : 32'h0));
        chk("pre_rst_we", 64'(gpr_we), 64'h1);
        #2 rst = 1'b1;
        #1 chk("async_rst", 64'({busy, gpr_we, gpr_waddr, gpr_wdata}), 64'h0);
        tick();
        rst = 1'b0;

        // Randomized traffic obeying the hold rule.
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!exu_valid || acc_e) begin
                exu_valid = ($urandom_range(0, 2) != 0);
                exu_rd    = 5'($urandom_range(0, 7));
                exu_data  = $urandom;
            end
            if (!lsu_valid || acc_l) begin
                lsu_valid = ($urandom_range(0, 2) != 0);
                lsu_rd    = 5'($urandom_range(0, 7));
                lsu_data  = $urandom;
            end
            issue_valid = ($urandom_range(0, 1) != 0);
            issue_rd    = 5'($urandom_range(0, 7));
            rs1         = 5'($urandom_range(0, 7));
            rs2         = 5'($urandom_range(0, 31));
            if (c == 1500) do_reset();
        end
        exu_valid = 0; lsu_valid = 0; issue_valid = 0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
